egress_serializer: RTL and testbench

//  Downstream stage of the CoDel dequeue path. Consumes packet + drop flag each cycle, discards dropped packets,

---
 rtl/egress_serializer_if.sv | 32 +++
 rtl/egress_serializer.sv | 153 +++++++++++++++
 tb/tb_egress_serializer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/egress_serializer_if.sv
// Bus bundle between the CoDel dequeue stage, the egress serializer and the egress sink.
// master drives the ingress packet, sink ready and stats clear; slave is the serializer.
interface egress_serializer_if #(
    parameter int PKT_W  = 64,
    parameter int BEAT_W = 8,
    parameter int CNT_W  = 32
);
    logic [PKT_W-1:0]  i__packet;
    logic              i__drop_packet;
    logic              o__link_ready;
    logic              o__beat_valid;
    logic [BEAT_W-1:0] o__beat_data;
    logic              o__beat_sop;
    logic              o__beat_eop;
    logic              i__beat_ready;
    logic              i__clear_stats;
    logic [CNT_W-1:0]  o__tx_count;
    logic [CNT_W-1:0]  o__drop_count;
    logic              o__overflow;

    modport master (
        output i__packet, i__drop_packet, i__beat_ready, i__clear_stats,
        input  o__link_ready, o__beat_valid, o__beat_data, o__beat_sop, o__beat_eop,
               o__tx_count, o__drop_count, o__overflow
    );

    modport slave (
        input  i__packet, i__drop_packet, i__beat_ready, i__clear_stats,
        output o__link_ready, o__beat_valid, o__beat_data, o__beat_sop, o__beat_eop,
               o__tx_count, o__drop_count, o__overflow
    );
endinterface

// File: rtl/egress_serializer.sv
// Egress serializer: drops flagged packets, buffers accepted ones and emits each as
// PKT_W/BEAT_W beats (MSB slice first) with saturating tx/drop statistics.
//
// state | meaning
// IDLE  | nothing in flight; loads the buffer head as soon as one is present
// SEND  | shift register holds a packet; current beat offered on the egress link
module egress_serializer #(
    parameter int PKT_W     = 64,
    parameter int BEAT_W    = 8,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input logic                clk,
    input logic                reset,
    egress_serializer_if.slave bus
);
    localparam int NBEATS = PKT_W / BEAT_W;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);

    if (PKT_W % BEAT_W != 0) begin : g_width_check
        $error("egress_serializer: PKT_W must be a multiple of BEAT_W");
    end
    if (BUF_DEPTH < 1) begin : g_depth_check
        $error("egress_serializer: BUF_DEPTH must be at least 1");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    logic [PKT_W-1:0]  shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic [PKT_W-1:0]  buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  tx_q, drop_q;
    logic              overflow_q;

    logic in_valid, link_ready, push, lost, drop_ev;
    logic not_empty, last_beat, eop_fire, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The packet's valid bit is its MSB, so it also travels in the first beat.
    assign in_valid   = bus.i__packet[PKT_W-1];
    assign link_ready = (occ_q < OCC_W'(BUF_DEPTH));
    assign push       = in_valid & ~bus.i__drop_packet & link_ready;
    assign lost       = in_valid & ~bus.i__drop_packet & ~link_ready;
    assign drop_ev    = in_valid & bus.i__drop_packet;
    assign not_empty  = (occ_q != '0);
    assign last_beat  = (idx_q == IDX_W'(NBEATS - 1));
    assign eop_fire   = (state_q == SEND) & bus.i__beat_ready & last_beat;
    assign pop        = not_empty & ((state_q == IDLE) | eop_fire);

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= bus.i__packet;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (not_empty) begin
                        shift_q <= buf_q[rd_ptr_q];
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (bus.i__beat_ready) begin
                        if (last_beat) begin
                            // Chain straight into the next packet so the link sees no bubble.
                            if (not_empty) begin
                                shift_q <= buf_q[rd_ptr_q];
                                idx_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            shift_q <= shift_q << BEAT_W;
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q       <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else if (bus.i__clear_stats) begin
            tx_q       <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (eop_fire && (tx_q != '1)) begin
                tx_q <= tx_q + CNT_W'(1);
            end
            if (drop_ev && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
            if (lost) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.o__link_ready = link_ready;
    assign bus.o__beat_valid = (state_q == SEND);
    assign bus.o__beat_data  = (state_q == SEND) ? shift_q[PKT_W-1 -: BEAT_W] : '0;
    assign bus.o__beat_sop   = (state_q == SEND) & (idx_q == '0);
    assign bus.o__beat_eop   = (state_q == SEND) & last_beat;
    assign bus.o__tx_count   = tx_q;
    assign bus.o__drop_count = drop_q;
    assign bus.o__overflow   = overflow_q;
endmodule

// File: tb/tb_egress_serializer.sv
// Directed bench for egress_serializer: a beat-queue model checks every egress handshake,
// literal expectations pin beat order, latency, counters and reset behaviour.
module tb_egress_serializer;
    logic clk;
    logic reset;

    egress_serializer_if #(.PKT_W(64), .BEAT_W(8), .CNT_W(32)) b ();
    egress_serializer_if #(.PKT_W(64), .BEAT_W(8), .CNT_W(4))  b4 ();

    egress_serializer #(.PKT_W(64), .BEAT_W(8), .BUF_DEPTH(2), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    egress_serializer #(.PKT_W(64), .BEAT_W(8), .BUF_DEPTH(2), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    fails   = 0;
    int    exp_tx   = 0;
    int    exp_drop = 0;
    int    exp_ovf  = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted packet becomes 8 beats, MSB byte first.
    task automatic model_push(logic [63:0] pkt);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{d: pkt[63 - 8*i -: 8], sop: (i == 0), eop: (i == 7)});
        end
    endtask

    logic       hold_v = 1'b0;
    logic [10:0] held;

    always @(negedge clk) begin
        if (!reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                vectors++;
                if ({b.o__beat_valid, b.o__beat_data, b.o__beat_sop, b.o__beat_eop} !== held) begin
                    fails++;
                    $display("FAIL hold: got %0h expected %0h at %0t",
                             {b.o__beat_valid, b.o__beat_data, b.o__beat_sop, b.o__beat_eop}, held, $time);
                end
            end
            hold_v = 1'b0;
            if (b.o__beat_valid) begin
                if (b.i__beat_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL beat: got unexpected beat %0h expected none at %0t", b.o__beat_data, $time);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        if ({b.o__beat_data, b.o__beat_sop, b.o__beat_eop} !== {e.d, e.sop, e.eop}) begin
                            fails++;
                            $display("FAIL beat: got d=%0h sop=%0b eop=%0b expected d=%0h sop=%0b eop=%0b at %0t",
                                     b.o__beat_data, b.o__beat_sop, b.o__beat_eop, e.d, e.sop, e.eop, $time);
                        end
                        if (e.eop) exp_tx++;
                    end
                end else begin
                    hold_v = 1'b1;
                    held   = {b.o__beat_valid, b.o__beat_data, b.o__beat_sop, b.o__beat_eop};
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [63:0] pkt, logic drop, logic exp_rdy);
        b.i__packet      = pkt;
        b.i__drop_packet = drop;
        chk("link_ready", {63'd0, b.o__link_ready}, {63'd0, exp_rdy});
        tick();
        b.i__packet      = '0;
        b.i__drop_packet = 1'b0;
        if (pkt[63]) begin
            if (drop)         exp_drop++;
            else if (exp_rdy) model_push(pkt);
            else              exp_ovf = 1;
        end
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        @(negedge clk);
        while (!b.o__beat_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {63'd0, b.o__beat_valid}, 64'd1);
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || b.o__beat_valid) && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk(name, exp_q.size(), 64'd0);
    endtask

    task automatic chk_stats(string tag);
        chk({tag, " tx_count"},   b.o__tx_count,   exp_tx);
        chk({tag, " drop_count"}, b.o__drop_count, exp_drop);
        chk({tag, " overflow"},   {63'd0, b.o__overflow}, exp_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit [8];
        lit = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h89};

        reset = 1'b0;
        b.i__packet = '0;  b.i__drop_packet = 1'b0;  b.i__beat_ready = 1'b1;  b.i__clear_stats = 1'b0;
        b4.i__packet = '0; b4.i__drop_packet = 1'b0; b4.i__beat_ready = 1'b1; b4.i__clear_stats = 1'b0;

        // Reset values
        #3;
        chk("rst link_ready", {63'd0, b.o__link_ready}, 64'd1);
        chk("rst beat_valid", {63'd0, b.o__beat_valid}, 64'd0);
        chk("rst beat_data",  {56'd0, b.o__beat_data}, 64'd0);
        chk("rst sop/eop",    {62'd0, b.o__beat_sop, b.o__beat_eop}, 64'd0);
        chk_stats("rst");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 1: single packet, latency N+2 and literal beat order
        push(64'hA1B2_C3D4_E5F6_0789, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1 latency N+1 idle", {63'd0, b.o__beat_valid}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1 beat valid", {63'd0, b.o__beat_valid}, 64'd1);
            chk("t1 beat data",  {56'd0, b.o__beat_data}, {56'd0, lit[i]});
            chk("t1 sop/eop",    {62'd0, b.o__beat_sop, b.o__beat_eop},
                {62'd0, (i == 0), (i == 7)});
        end
        @(negedge clk);
        chk("t1 back to idle", {63'd0, b.o__beat_valid}, 64'd0);
        tick();
        chk("t1 tx_count literal", b.o__tx_count, 64'd1);
        chk("t1 queue empty", exp_q.size(), 64'd0);

        // 2: drops, plus an invalid packet whose drop flag must be ignored
        push(64'h8123_4567_89AB_CDEF, 1'b1, 1'b1);
        push(64'h8000_0000_0000_0001, 1'b1, 1'b1);
        push(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        push(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        repeat (4) tick();
        chk("t2 drop_count literal", b.o__drop_count, 64'd3);
        chk("t2 link_ready", {63'd0, b.o__link_ready}, 64'd1);
        chk_stats("t2");

        // 3: backpressure mid-packet, buffer fills, overflow on the third packet
        push(64'h9011_2233_4455_6677, 1'b0, 1'b1);
        wait_valid("t3 first beat");
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        b.i__beat_ready = 1'b0;
        push(64'hC0DE_0001_0002_0003, 1'b0, 1'b1);
        push(64'hBEEF_1111_2222_3333, 1'b0, 1'b1);
        push(64'hDEAD_4444_5555_6666, 1'b0, 1'b0);
        chk("t3 overflow literal", {63'd0, b.o__overflow}, 64'd1);
        chk("t3 link_ready low", {63'd0, b.o__link_ready}, 64'd0);
        repeat (7) tick();
        chk("t3 still holding", {63'd0, b.o__beat_valid}, 64'd1);
        b.i__beat_ready = 1'b1;
        drain("t3 drain");
        chk_stats("t3");

        // 4: two buffered packets stream as 16 contiguous beats
        push(64'hA000_0000_0000_00A7, 1'b0, 1'b1);
        push(64'hB100_0000_0000_00B7, 1'b0, 1'b1);
        wait_valid("t4 first beat");
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk("t4 contiguous valid", {63'd0, b.o__beat_valid}, 64'd1);
            chk("t4 sop/eop", {62'd0, b.o__beat_sop, b.o__beat_eop},
                {62'd0, (i == 0 || i == 8), (i == 7 || i == 15)});
        end
        drain("t4 drain");
        chk_stats("t4");

        // Stats clear also clears overflow
        b.i__clear_stats = 1'b1;
        tick();
        b.i__clear_stats = 1'b0;
        exp_tx = 0; exp_drop = 0; exp_ovf = 0;
        chk_stats("clear");

        // 5: 4-bit counters saturate; clear beats a concurrent drop
        for (int i = 0; i < 17; i++) begin
            b4.i__packet = 64'h8000_0000_0000_0000 | 64'(i);
            b4.i__drop_packet = 1'b1;
            tick();
        end
        b4.i__packet = '0; b4.i__drop_packet = 1'b0;
        tick();
        chk("t5 drop saturate", {60'd0, b4.o__drop_count}, (17 > 15) ? 64'd15 : 64'd17);
        chk("t5 no beats", {63'd0, b4.o__beat_valid}, 64'd0);
        b4.i__packet = 64'h8000_0000_0000_0042; b4.i__drop_packet = 1'b1; b4.i__clear_stats = 1'b1;
        tick();
        b4.i__packet = '0; b4.i__drop_packet = 1'b0; b4.i__clear_stats = 1'b0;
        chk("t5 clear wins", {60'd0, b4.o__drop_count}, 64'd0);
        b4.i__packet = 64'h8000_0000_0000_0043; b4.i__drop_packet = 1'b1;
        tick();
        b4.i__packet = '0; b4.i__drop_packet = 1'b0;
        chk("t5 count after clear", {60'd0, b4.o__drop_count}, 64'd1);

        // 6: asynchronous reset mid-packet
        push(64'hE1E2_E3E4_E5E6_E7E8, 1'b0, 1'b1);
        push(64'hF1F2_F3F4_F5F6_F7F8, 1'b0, 1'b1);
        wait_valid("t6 first beat");
        repeat (3) @(negedge clk);
        chk("t6 mid-packet valid", {63'd0, b.o__beat_valid}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6 async valid drop", {63'd0, b.o__beat_valid}, 64'd0);
        chk("t6 async data zero", {56'd0, b.o__beat_data}, 64'd0);
        exp_q.delete();
        exp_tx = 0; exp_drop = 0; exp_ovf = 0;
        tick();
        tick();
        reset = 1'b1;
        chk("t6 link_ready", {63'd0, b.o__link_ready}, 64'd1);
        chk_stats("t6 post reset");
        repeat (12) tick();
        chk("t6 no stale beats", {63'd0, b.o__beat_valid}, 64'd0);
        push(64'hCAFE_F00D_1234_5678, 1'b0, 1'b1);
        drain("t6 drain");
        chk("t6 tx_count literal", b.o__tx_count, 64'd1);
        chk_stats("t6 end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
